// File: rtl/mult_4x4_share_arb.sv
// Round-robin sequencer sharing one external combinational 4x4 multiplier among NREQ requesters.
// Optional MULT_SHARE_ZERO_BYPASS_EN: accepts with a zero operand skip the multiply cycle.
module mult_4x4_share_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [3:0]        mul_a,
  output logic [3:0]        mul_b,
  input  logic [7:0]        mul_product,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_product,
  input  logic              rsp_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]     state;
  logic [IDW-1:0] last_grant;
  logic           hi_found, lo_found;
  logic [IDW-1:0] hi_id, lo_id;
  logic           win_valid;
  logic [IDW-1:0] win_id;
  logic [3:0]     sel_a, sel_b;
  logic           grant_window;
  logic           accept;
  logic           zero_skip;

  // Rotating priority: first valid index above last_grant, else first valid at or below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        if (i > 32'(last_grant)) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_id    = IDW'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_id    = IDW'(i);
        end
      end
    end
    win_valid = hi_found | lo_found;
    win_id    = hi_found ? hi_id : lo_id;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win_id) begin
        sel_a = req_a[4*i +: 4];
        sel_b = req_b[4*i +: 4];
      end
    end
  end

  assign grant_window = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign accept       = rst_n && grant_window && win_valid;
  assign req_ready    = accept ? (NREQ'(1) << win_id) : '0;
  assign rsp_valid    = (state == RESP);

`ifdef MULT_SHARE_ZERO_BYPASS_EN
  assign zero_skip = (sel_a == 4'd0) || (sel_b == 4'd0);
`else
  assign zero_skip = 1'b0;
`endif

  // rsp_id doubles as the owner-id register; it only changes on the edge that retires the old response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= IDW'(NREQ - 1);
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else if (accept) begin
      mul_a      <= sel_a;
      mul_b      <= sel_b;
      rsp_id     <= win_id;
      last_grant <= win_id;
      if (zero_skip) begin
        state       <= RESP;
        rsp_product <= '0;
      end else begin
        state <= CALC;
      end
    end else begin
      case (state)
        CALC: begin
          rsp_product <= mul_product;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_4x4_share_arb.md
# mult_4x4_share_arb

Round-robin arbiter and sequencer that shares one 4x4 unsigned multiplier among `NREQ` requesters. Each requester presents operands with a valid/ready handshake. The block grants one requester, drives the shared multiplier's operand inputs from registers, captures the 8-bit product and returns it with the requester's id on a single response channel with backpressure. The multiplier itself is combinational and external; this block owns operand sequencing and result return.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; legal range 2..8.
- `IDW`, 2: id width; must satisfy `2**IDW >= NREQ`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_a`  in  4*NREQ  operand a; requester i uses bits [4i+3:4i].
- `req_b`  in  4*NREQ  operand b; same packing as `req_a`.
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero.
- `mul_a`  out  4  registered operand a to the shared multiplier.
- `mul_b`  out  4  registered operand b to the shared multiplier.
- `mul_product`  in  8  combinational product from the shared multiplier (`mul_a*mul_b`).
- `rsp_valid`  out  1  response valid.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_product`  out  8  registered product.
- `rsp_ready`  in  1  response consumer accept.

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - CALC: operands are in `mul_a`/`mul_b`; the product is captured at the end of this cycle.
  - RESP: `rsp_valid`=1, waiting for `rsp_ready`.
- Grant window: the cycle is a grant window when the FSM is in IDLE, or in RESP with `rsp_ready`=1.
  - In a grant window, the round-robin winner among `req_valid` has its `req_ready` bit high (combinational).
  - `req_ready` is all zero outside grant windows.
- Round robin: the search starts at `(last_grant+1) mod NREQ`, and `last_grant` updates on every accept.
- Accept (`req_valid[i] & req_ready[i]`):
  - latch `req_a`/`req_b` slice i into `mul_a`/`mul_b`;
  - latch i into the id register;
  - go to CALC.
- Transitions:
  - CALC: `rsp_product`<=`mul_product`, go to RESP.
  - RESP with `rsp_ready`=1 and no accept: go to IDLE.
  - RESP with `rsp_ready`=1 and an accept: go to CALC. This gives back-to-back service.
- `rsp_product` and `rsp_id` are held stable while `rsp_valid`=1 and `rsp_ready`=0.
- `mul_a`/`mul_b` hold their last value outside CALC; they are not cleared.
- A requester dropping `req_valid` without a handshake is legal; it is simply not granted.
- Arithmetic: unsigned 4x4 -> 8 bits, no truncation. The maximum result is 15*15=225 (0xE1).

## Timing
- Reset (async assert, sync release): state=IDLE, `last_grant`=NREQ-1 (so requester 0 wins first), `mul_a`=`mul_b`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_product`=0.
- `req_ready`=0 while `rst_n`=0.
- Latency: accept at edge N -> CALC during cycle N+1 -> `rsp_valid`=1 from edge N+2.
- Throughput: 1 result per 2 cycles with `rsp_ready` held at 1; 1 per 3 cycles if the FSM returns to IDLE between transactions.
- Reset asserted mid-transaction: the transaction is discarded, no response is produced, and the FSM restarts in IDLE.
- Simultaneous response and new accept in RESP: the old response completes, and the new operands appear on `mul_a`/`mul_b` in the next cycle.

## Configuration
- `MULT_SHARE_ZERO_BYPASS_EN`:
  - Defined: an accept with either operand equal to 0 skips CALC. The FSM goes directly to RESP with `rsp_product`=0, a latency of 1 cycle. `mul_a`/`mul_b` are still updated.
  - Undefined: every accept goes through CALC, with a uniform 2-cycle latency.

## Test plan
- Reset, then requester 0 sends a=3, b=5 with `rsp_ready`=1 -> `rsp_valid` 2 cycles after accept, `rsp_id`=0, `rsp_product`=15, then back to IDLE.
- All four requesters valid continuously, operands (i+1, i+2), `rsp_ready`=1:
  - grants in order 0,1,2,3,0;
  - products 2, 6, 12, 20;
  - back-to-back, one result every 2 cycles.
- Requester 2 sends a=15, b=15 with `rsp_ready`=0 for 5 cycles -> `rsp_product`=225 and `rsp_id`=2 held stable; `req_ready`=0 throughout; released on the `rsp_ready` edge.
- Only requesters 1 and 3 are valid, after a grant to 1 -> next grant goes to 3, then back to 1 (0 and 2 are skipped).
- Assert `rst_n`=0 during CALC -> all outputs return to their reset values immediately; no response appears after release.
- a=0, b=9:
  - with `MULT_SHARE_ZERO_BYPASS_EN` defined -> `rsp_valid` 1 cycle after accept, product 0;
  - without it -> 2 cycles, product 0.
